// File: rtl/dispatch_queue_pkg.sv
// Shared opcode header for the dispatch path: RV32 major opcodes, the MULDIV funct7
// and the execution-unit index used for the one-hot routing vector.
package dispatch_queue_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam int NUM_UNITS = 4;

    typedef enum logic [1:0] {
        DISP_ALU    = 2'd0,
        DISP_LSU    = 2'd1,
        DISP_MULDIV = 2'd2,
        DISP_BR     = 2'd3
    } disp_e;

    // Legality is decided on the opcode alone, independent of what the decoder reports.
    function automatic logic opcode_legal(input logic [6:0] op);
        logic ok;
        case (op)
            OP_IMM, OP_OP, OP_LUI, OP_AUIPC,
            OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE: ok = 1'b1;
            default:           ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dispatch_queue_if.sv
// Fetch-side and unit-side handshakes of the dispatch queue, bundled as one interface.
interface dispatch_queue_if #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            flush_i;
    logic            inst_valid_i;
    logic [XLEN-1:0] inst_i;
    logic [XLEN-1:0] pc_i;
    logic            inst_ready_o;

    logic            alu_valid_o;
    logic            lsu_valid_o;
    logic            muldiv_valid_o;
    logic            br_valid_o;
    logic            alu_ready_i;
    logic            lsu_ready_i;
    logic            muldiv_ready_i;
    logic            br_ready_i;

    logic [XLEN-1:0] issue_inst_o;
    logic [XLEN-1:0] issue_pc_o;
    logic            illegal_o;
    logic [CW-1:0]   count_o;

    modport master (
        output flush_i, inst_valid_i, inst_i, pc_i,
        output alu_ready_i, lsu_ready_i, muldiv_ready_i, br_ready_i,
        input  inst_ready_o,
        input  alu_valid_o, lsu_valid_o, muldiv_valid_o, br_valid_o,
        input  issue_inst_o, issue_pc_o, illegal_o, count_o
    );

    modport slave (
        input  flush_i, inst_valid_i, inst_i, pc_i,
        input  alu_ready_i, lsu_ready_i, muldiv_ready_i, br_ready_i,
        output inst_ready_o,
        output alu_valid_o, lsu_valid_o, muldiv_valid_o, br_valid_o,
        output issue_inst_o, issue_pc_o, illegal_o, count_o
    );

endinterface

// File: rtl/dispatch_queue_decoder.sv
// Instruction class decoder: maps opcode/funct7 to the target execution unit.
// Unknown opcodes produce an all-zero result.
module decoder
    import dispatch_queue_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [6:0] funct7_i,
    output logic       alu_o,
    output logic       lsu_o,
    output logic       muldiv_o,
    output logic       br_o
);

    always_comb begin
        alu_o    = 1'b0;
        lsu_o    = 1'b0;
        muldiv_o = 1'b0;
        br_o     = 1'b0;
        case (opcode_i)
            OP_OP: begin
                if (funct7_i == FUNCT7_MULDIV) muldiv_o = 1'b1;
                else                           alu_o    = 1'b1;
            end
            OP_IMM, OP_LUI, OP_AUIPC:   alu_o = 1'b1;
            OP_LOAD, OP_STORE:          lsu_o = 1'b1;
            OP_JAL, OP_JALR, OP_BRANCH: br_o  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/dispatch_queue.sv
// In-order instruction buffer: circular FIFO of {inst, pc} whose head is classified
// and handed to exactly one execution unit; illegal heads are popped and flagged.
module dispatch_queue
    import dispatch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    dispatch_queue_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] inst_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q   [DEPTH];

    logic [XLEN-1:0]      head_inst;
    logic [XLEN-1:0]      head_pc;
    logic [NUM_UNITS-1:0] unit_raw;
    logic [NUM_UNITS-1:0] unit_sel;
    logic [NUM_UNITS-1:0] unit_valid;
    logic [NUM_UNITS-1:0] unit_ready;
    logic                 not_empty;
    logic                 legal;
    logic                 illegal;
    logic                 inst_ready;
    logic                 enq;
    logic                 deq;

    assign head_inst = inst_mem_q[rd_ptr_q];
    assign head_pc   = pc_mem_q[rd_ptr_q];

    decoder u_decoder (
        .opcode_i (head_inst[6:0]),
        .funct7_i (head_inst[31:25]),
        .alu_o    (unit_raw[DISP_ALU]),
        .lsu_o    (unit_raw[DISP_LSU]),
        .muldiv_o (unit_raw[DISP_MULDIV]),
        .br_o     (unit_raw[DISP_BR])
    );

    assign unit_ready[DISP_ALU]    = bus.alu_ready_i;
    assign unit_ready[DISP_LSU]    = bus.lsu_ready_i;
    assign unit_ready[DISP_MULDIV] = bus.muldiv_ready_i;
    assign unit_ready[DISP_BR]     = bus.br_ready_i;

    // A legal opcode the decoder does not claim still has to go somewhere: default to ALU.
    always_comb begin
        unit_sel = unit_raw;
        if (unit_raw == '0) unit_sel[DISP_ALU] = 1'b1;
    end

    assign not_empty  = (count_q != '0);
    assign legal      = opcode_legal(head_inst[6:0]);
    assign unit_valid = unit_sel & {NUM_UNITS{not_empty & legal}};
    assign illegal    = not_empty & ~legal;
    assign inst_ready = (count_q != CW'(DEPTH));

    assign enq = bus.inst_valid_i & inst_ready & ~bus.flush_i;
    assign deq = (|(unit_valid & unit_ready)) | illegal;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + AW'(1);
            if (deq) rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            inst_mem_q[wr_ptr_q] <= bus.inst_i;
            pc_mem_q[wr_ptr_q]   <= bus.pc_i;
        end
    end

    assign bus.inst_ready_o   = inst_ready;
    assign bus.alu_valid_o    = unit_valid[DISP_ALU];
    assign bus.lsu_valid_o    = unit_valid[DISP_LSU];
    assign bus.muldiv_valid_o = unit_valid[DISP_MULDIV];
    assign bus.br_valid_o     = unit_valid[DISP_BR];
    assign bus.issue_inst_o   = head_inst;
    assign bus.issue_pc_o     = head_pc;
    assign bus.illegal_o      = illegal;
    assign bus.count_o        = count_q;

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed bench for dispatch_queue: inputs change and outputs are sampled on the falling edge.
module tb_dispatch_queue;

    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] MUL  = 32'h022081B3;
    localparam logic [31:0] LW   = 32'h0000A203;
    localparam logic [31:0] ILL  = 32'hFFFFFFFF;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    dispatch_queue_if #(.DEPTH(4), .XLEN(32)) bus ();

    dispatch_queue #(.DEPTH(4), .XLEN(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    // {br, muldiv, lsu, alu}
    logic [3:0] vld;
    assign vld = {bus.br_valid_o, bus.muldiv_valid_o, bus.lsu_valid_o, bus.alu_valid_o};

    function automatic logic [31:0] addi_n(input int i);
        return 32'h00000093 | (32'(i) << 20);
    endfunction

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
        bus.inst_valid_i = v;
        bus.inst_i       = inst;
        bus.pc_i         = pc;
    endtask

    task automatic set_ready(input logic [3:0] r);
        {bus.br_ready_i, bus.muldiv_ready_i, bus.lsu_ready_i, bus.alu_ready_i} = r;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        total_cnt++;
        if ({bus.count_o, vld, bus.inst_ready_o, bus.illegal_o} !== {3'd0, 4'b0000, 1'b1, 1'b0})
            $display("FAIL reset_state: count=%0d vld=%b ready=%b ill=%b, want 0 0000 1 0",
                     bus.count_o, vld, bus.inst_ready_o, bus.illegal_o);
        else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_single_alu();
        set_ready(4'b1111);
        drive(1'b1, ADDI, 32'h100);
        total_cnt++;
        if (vld !== 4'b0000) $display("FAIL alu_empty_vld: got %b want 0000", vld);
        else pass_cnt++;
        step();
        drive(1'b0, 32'h0, 32'h0);
        total_cnt++;
        if ({vld, bus.issue_pc_o, bus.issue_inst_o, bus.count_o} !== {4'b0001, 32'h100, ADDI, 3'd1})
            $display("FAIL alu_issue: vld=%b pc=%h inst=%h count=%0d, want 0001 100 %h 1",
                     vld, bus.issue_pc_o, bus.issue_inst_o, bus.count_o, ADDI);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({vld, bus.count_o} !== {4'b0000, 3'd0})
            $display("FAIL alu_drain: vld=%b count=%0d, want 0000 0", vld, bus.count_o);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        set_ready(4'b1011);
        drive(1'b1, MUL, 32'h200);
        step();
        total_cnt++;
        if ({vld, bus.issue_pc_o, bus.count_o} !== {4'b0100, 32'h200, 3'd1})
            $display("FAIL b2b_mul_first: vld=%b pc=%h count=%0d, want 0100 200 1",
                     vld, bus.issue_pc_o, bus.count_o);
        else pass_cnt++;
        drive(1'b1, LW, 32'h204);
        step();
        drive(1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if ({vld, bus.issue_pc_o, bus.issue_inst_o, bus.count_o} !== {4'b0100, 32'h200, MUL, 3'd2})
                $display("FAIL b2b_mul_hold[%0d]: vld=%b pc=%h inst=%h count=%0d, want 0100 200 %h 2",
                         i, vld, bus.issue_pc_o, bus.issue_inst_o, bus.count_o, MUL);
            else pass_cnt++;
            step();
        end
        set_ready(4'b1111);
        total_cnt++;
        if ({vld, bus.issue_pc_o} !== {4'b0100, 32'h200})
            $display("FAIL b2b_mul_accept: vld=%b pc=%h, want 0100 200", vld, bus.issue_pc_o);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({vld, bus.issue_pc_o, bus.issue_inst_o, bus.count_o} !== {4'b0010, 32'h204, LW, 3'd1})
            $display("FAIL b2b_lw: vld=%b pc=%h inst=%h count=%0d, want 0010 204 %h 1",
                     vld, bus.issue_pc_o, bus.issue_inst_o, bus.count_o, LW);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({vld, bus.count_o} !== {4'b0000, 3'd0})
            $display("FAIL b2b_drain: vld=%b count=%0d, want 0000 0", vld, bus.count_o);
        else pass_cnt++;
    endtask

    task automatic test_routing();
        logic [31:0] insts [8];
        logic [3:0]  exp_v [8];
        insts = '{32'h123450B7, 32'h00001097, 32'h00112023, 32'h0000006F,
                  32'h00008067, 32'h00208463, 32'h402081B3, 32'h0220C1B3};
        exp_v = '{4'b0001, 4'b0001, 4'b0010, 4'b1000,
                  4'b1000, 4'b1000, 4'b0001, 4'b0100};
        set_ready(4'b1111);
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) begin
                total_cnt++;
                if ({vld, bus.issue_pc_o, bus.illegal_o} !== {exp_v[i-1], 32'h700 + 32'(4*(i-1)), 1'b0})
                    $display("FAIL route[%0d]: vld=%b pc=%h ill=%b, want %b %h 0", i-1, vld,
                             bus.issue_pc_o, bus.illegal_o, exp_v[i-1], 32'h700 + 32'(4*(i-1)));
                else pass_cnt++;
            end
            if (i < 8) drive(1'b1, insts[i], 32'h700 + 32'(4*i));
            else       drive(1'b0, 32'h0, 32'h0);
            step();
        end
    endtask

    task automatic test_full_wrap();
        set_ready(4'b0000);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, addi_n(i), 32'h300 + 32'(4*i));
            step();
        end
        total_cnt++;
        if ({bus.count_o, bus.inst_ready_o, vld, bus.issue_pc_o} !== {3'd4, 1'b0, 4'b0001, 32'h300})
            $display("FAIL full: count=%0d ready=%b vld=%b pc=%h, want 4 0 0001 300",
                     bus.count_o, bus.inst_ready_o, vld, bus.issue_pc_o);
        else pass_cnt++;
        drive(1'b1, addi_n(4), 32'h310);
        set_ready(4'b0001);
        step();
        for (int k = 1; k <= 10; k++) begin
            total_cnt++;
            if ({bus.count_o, bus.inst_ready_o, vld, bus.issue_pc_o, bus.issue_inst_o} !==
                {3'd3, 1'b1, 4'b0001, 32'h300 + 32'(4*k), addi_n(k)})
                $display("FAIL wrap[%0d]: count=%0d ready=%b vld=%b pc=%h inst=%h, want 3 1 0001 %h %h",
                         k, bus.count_o, bus.inst_ready_o, vld, bus.issue_pc_o, bus.issue_inst_o,
                         32'h300 + 32'(4*k), addi_n(k));
            else pass_cnt++;
            drive(1'b1, addi_n(3 + k), 32'h300 + 32'(4*(3 + k)));
            step();
        end
        drive(1'b0, 32'h0, 32'h0);
        for (int j = 0; j < 3; j++) begin
            total_cnt++;
            if ({bus.count_o, bus.issue_pc_o} !== {3'(3 - j), 32'h300 + 32'(4*(11 + j))})
                $display("FAIL wrap_drain[%0d]: count=%0d pc=%h, want %0d %h", j, bus.count_o,
                         bus.issue_pc_o, 3 - j, 32'h300 + 32'(4*(11 + j)));
            else pass_cnt++;
            step();
        end
        total_cnt++;
        if ({bus.count_o, vld} !== {3'd0, 4'b0000})
            $display("FAIL wrap_empty: count=%0d vld=%b, want 0 0000", bus.count_o, vld);
        else pass_cnt++;
    endtask

    task automatic test_illegal();
        set_ready(4'b1111);
        drive(1'b1, ADDI, 32'h400);
        step();
        total_cnt++;
        if ({vld, bus.issue_pc_o, bus.illegal_o} !== {4'b0001, 32'h400, 1'b0})
            $display("FAIL ill_first: vld=%b pc=%h ill=%b, want 0001 400 0", vld, bus.issue_pc_o, bus.illegal_o);
        else pass_cnt++;
        drive(1'b1, ILL, 32'h404);
        step();
        total_cnt++;
        if ({vld, bus.issue_pc_o, bus.illegal_o} !== {4'b0000, 32'h404, 1'b1})
            $display("FAIL ill_pulse: vld=%b pc=%h ill=%b, want 0000 404 1", vld, bus.issue_pc_o, bus.illegal_o);
        else pass_cnt++;
        drive(1'b1, ADDI, 32'h408);
        step();
        drive(1'b0, 32'h0, 32'h0);
        total_cnt++;
        if ({vld, bus.issue_pc_o, bus.illegal_o} !== {4'b0001, 32'h408, 1'b0})
            $display("FAIL ill_next: vld=%b pc=%h ill=%b, want 0001 408 0", vld, bus.issue_pc_o, bus.illegal_o);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({bus.count_o, bus.illegal_o, vld} !== {3'd0, 1'b0, 4'b0000})
            $display("FAIL ill_drain: count=%0d ill=%b vld=%b, want 0 0 0000", bus.count_o, bus.illegal_o, vld);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        set_ready(4'b0000);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ADDI, 32'h500 + 32'(4*i));
            step();
        end
        total_cnt++;
        if (bus.count_o !== 3'd3) $display("FAIL flush_pre: count=%0d want 3", bus.count_o);
        else pass_cnt++;
        drive(1'b1, ADDI, 32'h50C);
        bus.flush_i = 1'b1;
        set_ready(4'b0001);
        step();
        bus.flush_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        set_ready(4'b0000);
        total_cnt++;
        if ({bus.count_o, vld, bus.inst_ready_o, bus.illegal_o} !== {3'd0, 4'b0000, 1'b1, 1'b0})
            $display("FAIL flush_clear: count=%0d vld=%b ready=%b ill=%b, want 0 0000 1 0",
                     bus.count_o, vld, bus.inst_ready_o, bus.illegal_o);
        else pass_cnt++;
        drive(1'b1, addi_n(7), 32'h600);
        step();
        drive(1'b0, 32'h0, 32'h0);
        total_cnt++;
        if ({bus.count_o, vld, bus.issue_pc_o} !== {3'd1, 4'b0001, 32'h600})
            $display("FAIL flush_after: count=%0d vld=%b pc=%h, want 1 0001 600",
                     bus.count_o, vld, bus.issue_pc_o);
        else pass_cnt++;
        set_ready(4'b1111);
        step();
        total_cnt++;
        if (bus.count_o !== 3'd0) $display("FAIL flush_drain: count=%0d want 0", bus.count_o);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        set_ready(4'b0000);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, LW, 32'h800 + 32'(4*i));
            step();
        end
        drive(1'b0, 32'h0, 32'h0);
        total_cnt++;
        if ({bus.count_o, vld} !== {3'd3, 4'b0010})
            $display("FAIL areset_pre: count=%0d vld=%b, want 3 0010", bus.count_o, vld);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({bus.count_o, vld, bus.inst_ready_o, bus.illegal_o} !== {3'd0, 4'b0000, 1'b1, 1'b0})
            $display("FAIL areset_async: count=%0d vld=%b ready=%b ill=%b, want 0 0000 1 0",
                     bus.count_o, vld, bus.inst_ready_o, bus.illegal_o);
        else pass_cnt++;
        step();
        rst_n = 1'b1;
        drive(1'b1, ADDI, 32'h900);
        step();
        drive(1'b0, 32'h0, 32'h0);
        total_cnt++;
        if ({bus.count_o, vld, bus.issue_pc_o} !== {3'd1, 4'b0001, 32'h900})
            $display("FAIL areset_resume: count=%0d vld=%b pc=%h, want 1 0001 900",
                     bus.count_o, vld, bus.issue_pc_o);
        else pass_cnt++;
    endtask

    initial begin
        bus.flush_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        set_ready(4'b0000);
        step();
        test_reset();
        test_single_alu();
        test_back_to_back();
        test_routing();
        test_full_wrap();
        test_illegal();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
